// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation encoding, FSM states and the
// status-flag bundle carried between the datapath and the output registers.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_ADC = 3'b101,
        OP_SBC = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_MUL_RUN
    } state_e;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } flags_t;

endpackage

// File: rtl/mul_shift_add.sv
// Unsigned right-shifting shift-add multiplier: one partial-product step per
// step_i cycle, product available combinationally alongside the final step.
module mul_shift_add #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] prod_hi_o,
    output logic [WIDTH-1:0] prod_lo_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] mplier_d;

    // The multiplier register doubles as the low half of the product as it shifts out.
    assign partial  = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_d    = partial[WIDTH:1];
    assign mplier_d = {partial[0], mplier_q[WIDTH-1:1]};

    assign done_o    = step_i && (cnt_q == CNT_W'(WIDTH - 1));
    assign prod_hi_o = acc_d;
    assign prod_lo_o = mplier_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step_i) begin
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops, multi-cycle unsigned MUL,
// registered result and flags that hold between done pulses.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_out,
    output logic [WIDTH-1:0] result_hi_out,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             negative_flag,
    output logic             overflow_flag
);

    localparam int MSB = WIDTH - 1;

    alu_op_e          op;
    state_e           state_q, state_d;
    flags_t           flags_q, flags_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             done_q, done_d;
    logic             cin, bin;
    logic [WIDTH:0]   sum_w, dif_w;
    logic             mul_start, mul_step, mul_done;
    logic [WIDTH-1:0] prod_hi, prod_lo;

    assign op    = alu_op_e'(alu_op);
    assign cin   = (op == OP_ADC) ? flags_q.c : 1'b0;
    assign bin   = (op == OP_SBC) ? flags_q.c : 1'b0;
    assign sum_w = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, cin};
    assign dif_w = {1'b0, a_in} - {1'b0, b_in} - {{WIDTH{1'b0}}, bin};

    mul_shift_add #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_i   (mul_start),
        .step_i    (mul_step),
        .a_i       (a_in),
        .b_i       (b_in),
        .done_o    (mul_done),
        .prod_hi_o (prod_hi),
        .prod_lo_o (prod_lo)
    );

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        hi_d      = hi_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        mul_start = 1'b0;
        mul_step  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && op == OP_MUL) begin
                    mul_start = 1'b1;
                    state_d   = ST_MUL_RUN;
                end else if (start) begin
                    done_d    = 1'b1;
                    hi_d      = '0;
                    flags_d.c = 1'b0;
                    flags_d.v = 1'b0;
                    case (op)
                        OP_ADD, OP_ADC: begin
                            res_d     = sum_w[MSB:0];
                            flags_d.c = sum_w[WIDTH];
                            flags_d.v = (a_in[MSB] == b_in[MSB]) && (sum_w[MSB] != a_in[MSB]);
                        end
                        OP_SUB, OP_SBC: begin
                            res_d     = dif_w[MSB:0];
                            flags_d.c = dif_w[WIDTH];
                            flags_d.v = (a_in[MSB] != b_in[MSB]) && (dif_w[MSB] != a_in[MSB]);
                        end
                        OP_AND:  res_d = a_in & b_in;
                        OP_OR:   res_d = a_in | b_in;
                        OP_XOR:  res_d = a_in ^ b_in;
                        default: res_d = res_q;
                    endcase
                    flags_d.z = (res_d == '0);
                    flags_d.n = res_d[MSB];
                end
            end
            ST_MUL_RUN: begin
                mul_step = 1'b1;
                if (mul_done) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    res_d     = prod_lo;
                    hi_d      = prod_hi;
                    flags_d.z = ({prod_hi, prod_lo} == '0);
                    flags_d.c = |prod_hi;
                    flags_d.n = prod_hi[MSB];
                    flags_d.v = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            hi_q    <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    assign busy          = (state_q == ST_MUL_RUN);
    assign done          = done_q;
    assign result_out    = res_q;
    assign result_hi_out = hi_q;
    assign zero_flag     = flags_q.z;
    assign carry_flag    = flags_q.c;
    assign negative_flag = flags_q.n;
    assign overflow_flag = flags_q.v;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: integer-arithmetic reference model compared
// every cycle, directed corner sequences with literal expectations, then random traffic.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic         start   = 1'b0;
    logic [2:0]   alu_op  = 3'd0;
    logic [W-1:0] a_in    = '0;
    logic [W-1:0] b_in    = '0;
    logic         busy, done;
    logic [W-1:0] result_out, result_hi_out;
    logic         zero_flag, carry_flag, negative_flag, overflow_flag;

    int n_checks = 0;
    int n_fail   = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .alu_op        (alu_op),
        .a_in          (a_in),
        .b_in          (b_in),
        .busy          (busy),
        .done          (done),
        .result_out    (result_out),
        .result_hi_out (result_hi_out),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .negative_flag (negative_flag),
        .overflow_flag (overflow_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs as the spec defines them, from plain integer arithmetic.
    logic       exp_busy = 1'b0, exp_done = 1'b0;
    logic [7:0] exp_res  = 8'h00, exp_hi = 8'h00;
    logic       exp_z = 1'b0, exp_c = 1'b0, exp_n = 1'b0, exp_v = 1'b0;
    int         mul_left = 0;
    logic [7:0] mul_a = 8'h00, mul_b = 8'h00;

    task automatic model_apply(input alu_op_e op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, cy, u, s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        cy = ((op == OP_ADC || op == OP_SBC) && exp_c) ? 1 : 0;
        exp_hi = 8'h00;
        exp_c  = 1'b0;
        exp_v  = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                u = ua + ub + cy;
                s = sa + sb + cy;
                exp_res = u[7:0];
                exp_c   = (u > 255);
                exp_v   = (s > 127 || s < -128);
            end
            OP_SUB, OP_SBC: begin
                u = ua - ub - cy;
                s = sa - sb - cy;
                exp_res = u[7:0];
                exp_c   = (u < 0);
                exp_v   = (s > 127 || s < -128);
            end
            OP_AND: exp_res = a & b;
            OP_OR:  exp_res = a | b;
            OP_XOR: exp_res = a ^ b;
            default: begin
                u = ua * ub;
                exp_res = u[7:0];
                exp_hi  = u[15:8];
                exp_c   = (exp_hi != 0);
            end
        endcase
        if (op == OP_MUL) begin
            exp_z = ({exp_hi, exp_res} == 16'h0000);
            exp_n = exp_hi[7];
        end else begin
            exp_z = (exp_res == 8'h00);
            exp_n = exp_res[7];
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_busy = 1'b0; exp_done = 1'b0; exp_res = 8'h00; exp_hi = 8'h00;
            exp_z = 1'b0; exp_c = 1'b0; exp_n = 1'b0; exp_v = 1'b0;
            mul_left = 0;
        end else begin
            exp_done = 1'b0;
            if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) begin
                    model_apply(OP_MUL, mul_a, mul_b);
                    exp_done = 1'b1;
                end
            end else if (start) begin
                if (alu_op_e'(alu_op) == OP_MUL) begin
                    mul_a    = a_in;
                    mul_b    = b_in;
                    mul_left = W;
                end else begin
                    model_apply(alu_op_e'(alu_op), a_in, b_in);
                    exp_done = 1'b1;
                end
            end
            exp_busy = (mul_left > 0);
        end
    end

    always @(negedge clk) begin
        check("busy",     busy,          exp_busy);
        check("done",     done,          exp_done);
        check("result",   result_out,    exp_res);
        check("result_hi",result_hi_out, exp_hi);
        check("zero",     zero_flag,     exp_z);
        check("carry",    carry_flag,    exp_c);
        check("negative", negative_flag, exp_n);
        check("overflow", overflow_flag, exp_v);
    end

    task automatic expect_out(input string tag, input logic [7:0] res, input logic [7:0] hi,
                              input logic z, input logic c, input logic n, input logic v);
        check({tag, " result"}, result_out, res);
        check({tag, " hi"}, result_hi_out, hi);
        check({tag, " Z"}, zero_flag, z);
        check({tag, " C"}, carry_flag, c);
        check({tag, " N"}, negative_flag, n);
        check({tag, " V"}, overflow_flag, v);
    endtask

    // Pulse start for one cycle, then wait (bounded) for done; checks the latency in cycles.
    task automatic run_op(input alu_op_e op, input logic [7:0] a, input logic [7:0] b,
                          input int exp_lat, input string tag);
        int lat;
        start  = 1'b1;
        alu_op = op;
        a_in   = a;
        b_in   = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
    endtask

    function automatic logic [7:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h80;
            3:       return 8'h7F;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        int busy_cycles, done_cnt;

        #12;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        expect_out("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op(OP_ADD, 8'hFF, 8'h01, 1, "add_ff_01");
        expect_out("add_ff_01", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(OP_SUB, 8'h80, 8'h01, 1, "sub_80_01");
        expect_out("sub_80_01", 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(OP_SBC, 8'h00, 8'h00, 1, "sbc_00_00");
        expect_out("sbc_00_00", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(OP_ADD, 8'h7F, 8'h01, 1, "add_7f_01");
        expect_out("add_7f_01", 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        run_op(OP_ADC, 8'h00, 8'h00, 1, "adc_00_00");
        expect_out("adc_00_00", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // MUL with start requests hammered in every busy cycle; none may be taken.
        start = 1'b1; alu_op = OP_MUL; a_in = 8'hFF; b_in = 8'hFF;
        @(posedge clk); #1;
        busy_cycles = 0;
        done_cnt    = 0;
        for (int i = 0; i < 14; i++) begin
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) begin
                done_cnt++;
                expect_out("mul_ff_ff", 8'h01, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0);
            end
            start  = busy;
            alu_op = OP_ADD;
            a_in   = 8'h01;
            b_in   = 8'h01;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("mul busy cycles", busy_cycles, 8);
        check("mul done pulses", done_cnt, 1);
        expect_out("mul_hold", 8'h01, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0);

        run_op(OP_XOR, 8'hAA, 8'hAA, 1, "xor_aa_aa");
        expect_out("xor_aa_aa", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            a_in = 8'($urandom); b_in = 8'($urandom); alu_op = 3'($urandom);
            @(posedge clk); #1;
        end
        expect_out("xor_hold", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Abort a MUL with reset in the middle of its fourth step.
        run_op(OP_ADD, 8'h12, 8'h34, 1, "add_12_34");
        expect_out("add_12_34", 8'h46, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1; alu_op = OP_MUL; a_in = 8'h0F; b_in = 8'h0F;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2 reset_n = 1'b0;
        #1;
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        expect_out("abort", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset_n  = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_cnt++;
        end
        check("abort no done", done_cnt, 0);
        run_op(OP_AND, 8'hF0, 8'h3C, 1, "and_f0_3c");
        expect_out("and_f0_3c", 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic, including starts while busy and occasional resets.
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                @(posedge clk); #1;
                reset_n = 1'b1;
            end
            start  = ($urandom_range(0, 2) == 0);
            alu_op = 3'($urandom);
            a_in   = pick_operand();
            b_in   = pick_operand();
        end
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (legal 4..32).
REQ-002 SHALL have clk  input  1  rising-edge clock.
REQ-003 SHALL have reset_n  input  1  reset: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have start  input  1  single-cycle request, sampled only in IDLE.
REQ-005 SHALL have alu_op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 ADC, 110 SBC, 111 MUL.
REQ-006 SHALL have a_in, b_in  input  WIDTH  operands, captured on accepted start.
REQ-007 SHALL have busy  output  1  high while an operation is in progress.
REQ-008 SHALL have done  output  1  one-cycle pulse, result and flags valid.
REQ-009 SHALL have result_out  output  WIDTH  result (MUL: low half).
REQ-010 SHALL have result_hi_out  output  WIDTH  MUL high half, zero for other ops.
REQ-011 SHALL have zero_flag, carry_flag, negative_flag, overflow_flag  output  1 each  status of the latest result.

Function
REQ-012 SHALL be a two-state FSM: IDLE, MUL_RUN.
REQ-013 SHALL, in IDLE on start with op not MUL, register result and flags at that edge and pulse done the following cycle (done high in cycle N+1 for start in cycle N); busy stays low.
REQ-014 SHALL, in IDLE on start with MUL, capture operands, clear accumulator, enter MUL_RUN, assert busy.
REQ-015 SHALL, in MUL_RUN, perform one shift-add step per cycle for exactly WIDTH cycles, then return to IDLE, drop busy, update outputs and pulse done on the same edge.
REQ-016 SHALL ignore start while busy; captured operands not disturbed.
REQ-017 SHALL compute ADD/ADC as WIDTH+1-bit sum; carry_flag = bit WIDTH; ADC adds current carry_flag.
REQ-018 SHALL compute SUB/SBC as a - b (SBC: minus current carry_flag); carry_flag = 1 on borrow (unsigned a < subtrahend).
REQ-019 SHALL set overflow_flag per two's-complement sign rules for ADD/ADC/SUB/SBC; 0 for logic ops and MUL.
REQ-020 SHALL clear carry_flag for AND/OR/XOR; for MUL set carry_flag = OR of result_hi_out bits.
REQ-021 SHALL derive zero_flag and negative_flag from the new result in the same update (no one-op lag); MUL zero = full 2*WIDTH product zero, negative = result_hi_out MSB.
REQ-022 SHALL hold result and all flags unchanged between done pulses.
REQ-023 SHALL treat MUL as unsigned.
REQ-024 SHALL treat start with busy high and done high in same cycle as ignored (start only accepted from cycle after return to IDLE).

Reset
REQ-025 SHALL, on reset_n low, asynchronously force state IDLE, busy 0, done 0, result_out 0, result_hi_out 0, all flags 0.
REQ-026 SHALL abort an in-progress MUL on reset with no done pulse; first start after reset release accepted normally.

Structure
REQ-027 SHALL place the alu_op encoding enum and FSM state enum in shared package alu_pkg.
REQ-028 SHALL implement the shift-add iteration in sub-module mul_shift_add (WIDTH-parameterised, start/step/done).
REQ-029 SHALL keep operand, accumulator and counter registers sized from WIDTH only; counter width $clog2(WIDTH+1).

Verification (WIDTH=8)
REQ-030 ADD 0xFF+0x01 -> cycle N+1 done, result 0x00, Z=1 C=1 N=0 V=0.
REQ-031 SUB 0x80-0x01 -> result 0x7F, C=0, V=1, N=0; then SBC 0x00-0x00 with C=0 -> 0x00, Z=1.
REQ-032 ADD 0x7F+0x01 then ADC 0x00+0x00 -> first 0x80 V=1 N=1 C=0; second 0x00 Z=1.
REQ-033 MUL 0xFF*0xFF -> busy 8 cycles, done once, result 0x01, hi 0xFE, C=1, N=1; start pulses during busy ignored.
REQ-034 reset_n low at MUL step 4 -> all outputs 0 immediately, no done; next AND 0xF0&0x3C -> 0x30.
REQ-035 XOR 0xAA^0xAA after carry set -> result 0x00, Z=1, C=0, flags held until next done.
